// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register file slice.
//   - default datapath width / register count (shared with ALU and data memory)
//   - dump FSM state encoding
//   - packed-port slicing helper (LSB offset of port k in a packed bus)
package regfile_pkg;

  localparam int unsigned RF_DATA_W   = 16;
  localparam int unsigned RF_NUM_REGS = 16;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } rf_state_e;

  // LSB of port k in a bus of ports that are w bits wide each.
  function automatic int unsigned port_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: halt-triggered dump sequencer for regfile_mp.
//   clk, rst_n      clock, async active-low reset
//   hlt_i           halt request (level, sampled on clk)
//   dump_ready_i    consumer accepts current dump word
//   state_o         FSM state (RUN / DUMP / DONE)
//   idx_o           register index currently presented
//   load_o          storage must load dump data register this edge
//   load_addr_o     register index to load into the dump data register
//   dump_valid_o    dump word valid
//   dump_done_o     dump finished (sticky until reset)
//   busy_o          pipeline stall while dumping or done
module rf_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt_i,
  input  logic              dump_ready_i,
  output rf_state_e         state_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic              load_o,
  output logic [ADDR_W-1:0] load_addr_o,
  output logic              dump_valid_o,
  output logic              dump_done_o,
  output logic              busy_o
);

  // The hardwired zero register carries no state, so it is skipped.
  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // load_o fetches the word that becomes visible after this edge, so the
  // dump data is a registered copy that stays put through a stall.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    load_o      = 1'b0;
    load_addr_o = idx_q;
    case (state_q)
      ST_RUN: begin
        if (hlt_i) begin
          state_d     = ST_DUMP;
          idx_d       = FIRST;
          load_o      = 1'b1;
          load_addr_o = FIRST;
        end
      end
      ST_DUMP: begin
        if (dump_ready_i) begin
          if (idx_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d       = idx_q + ADDR_W'(1);
            load_o      = 1'b1;
            load_addr_o = idx_q + ADDR_W'(1);
          end
        end
      end
      default: ;  // DONE is terminal until reset
    endcase
  end

  assign state_o      = state_q;
  assign idx_o        = idx_q;
  assign dump_valid_o = (state_q == ST_DUMP);
  assign dump_done_o  = (state_q == ST_DONE);
  assign busy_o       = (state_q != ST_RUN);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file (ID stage) with
// registered reads, write-to-read bypass, optional hardwired zero register
// and a halt-triggered dump engine.
//   clk, rst_n           clock, async active-low reset
//   rd_addr, re          packed read addresses / per-port read enables
//   rd_data              packed registered read data (1-cycle latency)
//   we, wr_addr, wr_data write port (from WB)
//   hlt                  halt request, starts the dump
//   dump_valid/ready     dump handshake; dump_addr/dump_data the word
//   dump_done            dump complete (sticky); busy = stall pipeline
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        re,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     hlt,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     dump_done,
  output logic                     busy
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [DATA_W-1:0]               dump_data_q;
  rf_state_e                       state;
  logic                            load;
  logic [ADDR_W-1:0]               load_addr;
  logic                            we_eff;

  rf_dump_ctrl #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_dump_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .hlt_i        (hlt),
    .dump_ready_i (dump_ready),
    .state_o      (state),
    .idx_o        (dump_addr),
    .load_o       (load),
    .load_addr_o  (load_addr),
    .dump_valid_o (dump_valid),
    .dump_done_o  (dump_done),
    .busy_o       (busy)
  );

  // Writes only land in RUN (the halt cycle itself still commits) and never
  // touch the zero register.
  assign we_eff = we && (state == ST_RUN) && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      regs_q          <= '0;
    else if (we_eff) regs_q[wr_addr] <= wr_data;
  end

  // The first dump word is fetched on the halt edge, so a write in that same
  // cycle has to be forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_data_q <= '0;
    end else if (load) begin
      dump_data_q <= (we_eff && (wr_addr == load_addr)) ? wr_data : regs_q[load_addr];
    end
  end

  assign dump_data = dump_data_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat_d, rdat_q;

    assign ra = rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rdat_d = regs_q[ra];
      if (we_eff && (wr_addr == ra)) rdat_d = wr_data;
      if ((ZERO_REG != 0) && (ra == '0)) rdat_d = '0;
    end

    // Ports freeze while the dump engine owns the file.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             rdat_q <= '0;
      else if (re[k] && (state == ST_RUN))    rdat_q <= rdat_d;
    end

    assign rd_data[port_lsb(k, DATA_W) +: DATA_W] = rdat_q;
  end

endmodule
